// File: rtl/byte_striping_ctrl.sv
// Byte striping controller: collects bytes into 4-slot groups and emits each group
// across four lanes, preceded by a COM training sequence after every reset.
module byte_striping_ctrl #(
    parameter int          TRAIN_GROUPS = 4,
    parameter logic [7:0]  COM          = 8'hBC,
    parameter logic [7:0]  IDL          = 8'h7C,
    parameter logic [7:0]  PAD          = 8'hF7
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic        in_ready,
    output logic [7:0]  lane0,
    output logic [7:0]  lane1,
    output logic [7:0]  lane2,
    output logic [7:0]  lane3,
    output logic        lanes_valid,
    output logic [1:0]  state,
    output logic [15:0] byte_count,
    output logic        drop_err
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'b00,
        ST_IDLE   = 2'b01,
        ST_ACTIVE = 2'b10
    } state_t;

    state_t      state_q;
    logic [1:0]  phase;
    logic [3:0]  train_cnt;
    logic [7:0]  slot [3];
    logic [2:0]  slot_vld;

    // Handshake: a byte transfers on a rising edge where valid_in and in_ready are
    // both high; valid_in with in_ready low loses the byte and flags drop_err.
    logic accept;
    assign accept = valid_in && in_ready;

    // Group contents as seen at the group edge; slot 3 comes straight from data_in.
    logic [7:0] grp_byte [4];
    logic [3:0] grp_vld;
    logic [7:0] grp_lane [4];

    always_comb begin
        grp_byte[0] = slot[0];
        grp_byte[1] = slot[1];
        grp_byte[2] = slot[2];
        grp_byte[3] = data_in;
        grp_vld     = {accept, slot_vld};
        for (int i = 0; i < 4; i++) begin
            grp_lane[i] = grp_vld[i] ? grp_byte[i] : PAD;
        end
    end

    assign state = state_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_INIT;
            phase       <= 2'd0;
            train_cnt   <= 4'd0;
            slot[0]     <= 8'h00;
            slot[1]     <= 8'h00;
            slot[2]     <= 8'h00;
            slot_vld    <= 3'b000;
            lane0       <= 8'h00;
            lane1       <= 8'h00;
            lane2       <= 8'h00;
            lane3       <= 8'h00;
            lanes_valid <= 1'b0;
            in_ready    <= 1'b0;
            byte_count  <= 16'h0000;
            drop_err    <= 1'b0;
        end else begin
            phase       <= phase + 2'd1;
            lanes_valid <= 1'b0;

            if (valid_in && !in_ready) begin
                drop_err <= 1'b1;
            end

            if (accept && (byte_count != 16'hFFFF)) begin
                byte_count <= byte_count + 16'd1;
            end

            if (accept) begin
                case (phase)
                    2'd0: begin slot[0] <= data_in; slot_vld[0] <= 1'b1; end
                    2'd1: begin slot[1] <= data_in; slot_vld[1] <= 1'b1; end
                    2'd2: begin slot[2] <= data_in; slot_vld[2] <= 1'b1; end
                    default: ;
                endcase
            end

            if (phase == 2'd3) begin
                lanes_valid <= 1'b1;
                slot_vld    <= 3'b000;
                case (state_q)
                    ST_INIT: begin
                        lane0 <= COM;
                        lane1 <= COM;
                        lane2 <= COM;
                        lane3 <= COM;
                        if (train_cnt == 4'(TRAIN_GROUPS - 1)) begin
                            state_q  <= ST_IDLE;
                            in_ready <= 1'b1;
                        end else begin
                            train_cnt <= train_cnt + 4'd1;
                        end
                    end
                    default: begin
                        if (|grp_vld) begin
                            lane0   <= grp_lane[0];
                            lane1   <= grp_lane[1];
                            lane2   <= grp_lane[2];
                            lane3   <= grp_lane[3];
                            state_q <= ST_ACTIVE;
                        end else begin
                            lane0   <= IDL;
                            lane1   <= IDL;
                            lane2   <= IDL;
                            lane3   <= IDL;
                            state_q <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_byte_striping_ctrl.sv
// Bench for byte_striping_ctrl: a group-level reference model pushes each expected
// lane group into a queue; a monitor pops and compares on every lanes_valid strobe.
module tb_byte_striping_ctrl;

    localparam int TG = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        valid_in = 1'b0;
    logic        in_ready;
    logic [7:0]  lane0, lane1, lane2, lane3;
    logic        lanes_valid;
    logic [1:0]  state;
    logic [15:0] byte_count;
    logic        drop_err;

    byte_striping_ctrl #(.TRAIN_GROUPS(TG)) dut (
        .CLK(CLK), .RESET(RESET), .data_in(data_in), .valid_in(valid_in),
        .in_ready(in_ready), .lane0(lane0), .lane1(lane1), .lane2(lane2), .lane3(lane3),
        .lanes_valid(lanes_valid), .state(state), .byte_count(byte_count), .drop_err(drop_err)
    );

    // clock / cycle counter
    always #5 CLK = ~CLK;
    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // scoreboard: {tag[31:0], lane0..3, state, byte_count, drop_err, in_ready}
    logic [83:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int         mcyc;
    int         groups;
    logic [15:0] m_cnt;
    logic        m_drop;
    logic [7:0]  m_byte [4];
    bit          m_vld [4];

    task automatic model_reset();
        mcyc = 0; groups = 0; m_cnt = 16'h0000; m_drop = 1'b0;
        for (int i = 0; i < 4; i++) begin m_vld[i] = 1'b0; m_byte[i] = 8'h00; end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one cycle of stimulus plus the model's view of that cycle
    task automatic drive(input logic v, input logic [7:0] d);
        int p;
        bit rdy, any;
        logic [7:0] ln [4];
        logic [1:0] st;
        @(negedge CLK);
        RESET = 1'b0; valid_in = v; data_in = d;
        p = mcyc % 4;
        rdy = (groups >= TG);
        if (v) begin
            if (rdy) begin
                m_byte[p] = d; m_vld[p] = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else begin
                m_drop = 1'b1;
            end
        end
        if (p == 3) begin
            if (!rdy) begin
                for (int i = 0; i < 4; i++) ln[i] = 8'hBC;
                groups++;
                st = (groups >= TG) ? 2'b01 : 2'b00;
            end else begin
                any = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    ln[i] = m_vld[i] ? m_byte[i] : 8'hF7;
                    any = any | m_vld[i];
                end
                if (!any) for (int i = 0; i < 4; i++) ln[i] = 8'h7C;
                st = any ? 2'b10 : 2'b01;
            end
            exp_q.push_back({32'(cyc + 1), ln[0], ln[1], ln[2], ln[3], st, m_cnt, m_drop,
                             (groups >= TG) ? 1'b1 : 1'b0});
            for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
        end
        mcyc++;
    endtask

    task automatic drive_group(input logic [3:0] v, input logic [31:0] d);
        for (int i = 0; i < 4; i++) drive(v[i], d[8*i +: 8]);
    endtask

    task automatic reset_dut();
        @(negedge CLK);
        RESET = 1'b1; valid_in = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_lanes", {32'h0, lane0, lane1, lane2, lane3}, 64'h0);
        check("reset_ctrl", {44'h0, lanes_valid, state, in_ready, byte_count},
              {44'h0, 1'b0, 2'b00, 1'b0, 16'h0000});
        check("reset_drop", {63'h0, drop_err}, 64'h0);
        model_reset();
    endtask

    // monitor
    initial begin
        logic [83:0] act, e;
        forever begin
            @(posedge CLK);
            #1;
            while (exp_q.size() > 0 && exp_q[0][83:52] < cyc) begin
                e = exp_q.pop_front();
                vectors++; miscompares++;
                $display("FAIL missed_pulse: no lanes_valid at cycle %0d, expected group %h", e[83:52], e[51:0]);
            end
            if (lanes_valid) begin
                vectors++;
                act = {32'(cyc), lane0, lane1, lane2, lane3, state, byte_count, drop_err, in_ready};
                if (exp_q.size() == 0 || exp_q[0][83:52] != cyc) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse: cycle %0d got %h expected none", cyc, act[51:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        miscompares++;
                        $display("FAIL group: cycle %0d got %h expected %h", cyc, act[51:0], e[51:0]);
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        model_reset();
        reset_dut();
        repeat (20) drive(1'b0, 8'h00);                  // training then one idle group
        drive_group(4'b1111, 32'h04030201);
        drive_group(4'b0010, 32'h0000AA00);
        drive_group(4'b0000, 32'h0);
        repeat (200) drive(1'($urandom_range(0, 1)), 8'($urandom));

        reset_dut();                                     // bytes offered during training
        repeat (24) drive(1'b1, 8'($urandom));
        repeat (4) drive(1'b0, 8'h00);

        reset_dut();                                     // reset in phase 2 of an active group
        repeat (16) drive(1'b0, 8'h00);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h66);
        reset_dut();
        repeat (20) drive(1'b0, 8'h00);

        repeat (65540) drive(1'b1, 8'($urandom_range(0, 255)));   // run byte_count into saturation
        repeat (8) drive(1'b0, 8'h00);
        @(negedge CLK);
        check("byte_count_sat", {48'h0, byte_count}, {48'h0, 16'hFFFF});
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
